imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 128 ++++++++++++
 tb/tb_imm_encoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a signed immediate into I/S/B/J instruction bits [31:7]
// and queues the result, with a range-error flag, in a 2-entry FIFO.
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_imm,
  input  logic [1:0]  in_immsrc,
  input  logic [24:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_J = 2'b11} fmt_e;
  typedef enum logic [1:0] {OCC_EMPTY = 2'd0, OCC_ONE = 2'd1, OCC_FULL = 2'd2} occ_e;

  fmt_e        w_fmt;
  logic [24:0] w_instr;
  logic        w_err;
  logic        w_push;
  logic        w_pop;

  occ_e        r_occ;
  logic [24:0] r_instr0;
  logic        r_err0;
  logic [24:0] r_instr1;
  logic        r_err1;
  logic [7:0]  r_err_count;

  assign w_fmt = fmt_e'(in_immsrc);

  // Bit k of w_instr is instruction bit k+7; uncovered bits pass through from in_base.
  always_comb begin
    w_instr = in_base;
    w_err   = 1'b0;
    case (w_fmt)
      FMT_I: begin
        w_instr[24:13] = in_imm[11:0];
        w_err          = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_S: begin
        w_instr[24:18] = in_imm[11:5];
        w_instr[4:0]   = in_imm[4:0];
        w_err          = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_B: begin
        w_instr[24]    = in_imm[12];
        w_instr[23:18] = in_imm[10:5];
        w_instr[4:1]   = in_imm[4:1];
        w_instr[0]     = in_imm[11];
        w_err          = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      end
      FMT_J: begin
        w_instr[24]    = in_imm[20];
        w_instr[23:14] = in_imm[10:1];
        w_instr[13]    = in_imm[11];
        w_instr[12:5]  = in_imm[19:12];
        w_err          = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      end
      default: begin
        w_instr = in_base;
        w_err   = 1'b0;
      end
    endcase
  end

  assign in_ready  = (r_occ != OCC_FULL);
  assign out_valid = (r_occ != OCC_EMPTY);
  assign w_push    = in_valid && (r_occ != OCC_FULL);
  assign w_pop     = out_ready && (r_occ != OCC_EMPTY);

  // Entry 0 is always the head and is zeroed when it drains, so outputs read 0 when empty.
  assign out_instr = r_instr0;
  assign out_err   = r_err0;
  assign err_count = r_err_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ       <= OCC_EMPTY;
      r_instr0    <= '0;
      r_err0      <= 1'b0;
      r_instr1    <= '0;
      r_err1      <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_push && w_err && (r_err_count != '1))
        r_err_count <= r_err_count + 8'd1;
      case (r_occ)
        OCC_EMPTY: begin
          if (w_push) begin
            r_instr0 <= w_instr;
            r_err0   <= w_err;
            r_occ    <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_push && w_pop) begin
            r_instr0 <= w_instr;
            r_err0   <= w_err;
          end else if (w_push) begin
            r_instr1 <= w_instr;
            r_err1   <= w_err;
            r_occ    <= OCC_FULL;
          end else if (w_pop) begin
            r_instr0 <= '0;
            r_err0   <= 1'b0;
            r_occ    <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (w_pop) begin
            r_instr0 <= r_instr1;
            r_err0   <= r_err1;
            r_instr1 <= '0;
            r_err1   <= 1'b0;
            r_occ    <= OCC_ONE;
          end
        end
        default: r_occ <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed corner cases plus random traffic against a
// queue-based reference model built from the format and range rules.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_imm;
  logic [1:0]  in_immsrc;
  logic [24:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [25:0] m_q[$];
  int unsigned m_errcnt = 0;

  imm_encoder u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_immsrc (in_immsrc),
    .in_base   (in_base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Returns {err, instr[31:7]}; error is a signed range / alignment test on the value.
  function automatic logic [25:0] ref_enc(input logic [31:0] imm, input logic [1:0] src,
                                          input logic [24:0] base);
    logic [31:0] ins;
    int          v;
    logic        e;
    ins = {base, 7'b0};
    v   = imm;
    e   = 1'b0;
    case (src)
      2'd0: begin
        ins[31:20] = imm[11:0];
        e = (v < -2048) || (v > 2047);
      end
      2'd1: begin
        ins[31:25] = imm[11:5];
        ins[11:7]  = imm[4:0];
        e = (v < -2048) || (v > 2047);
      end
      2'd2: begin
        ins[31]    = imm[12];
        ins[30:25] = imm[10:5];
        ins[11:8]  = imm[4:1];
        ins[7]     = imm[11];
        e = (v < -4096) || (v > 4095) || (imm[0] == 1'b1);
      end
      default: begin
        ins[31]    = imm[20];
        ins[30:21] = imm[10:1];
        ins[20]    = imm[11];
        ins[19:12] = imm[19:12];
        e = (v < -1048576) || (v > 1048575) || (imm[0] == 1'b1);
      end
    endcase
    return {e, ins[31:7]};
  endfunction

  // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic        push;
    logic        pop;
    logic [25:0] e;
    logic [25:0] head;
    @(negedge clk);
    head = (m_q.size() > 0) ? m_q[0] : 26'd0;
    check("in_ready",  {31'd0, in_ready},  {31'd0, (m_q.size() < 2)});
    check("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
    check("out_instr", {7'd0, out_instr},  {7'd0, head[24:0]});
    check("out_err",   {31'd0, out_err},   {31'd0, head[25]});
    check("err_count", {24'd0, err_count}, m_errcnt);
    e    = ref_enc(in_imm, in_immsrc, in_base);
    push = in_valid && (m_q.size() < 2);
    pop  = out_ready && (m_q.size() > 0);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_errcnt = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(e);
        if (e[25] && m_errcnt < 255) m_errcnt++;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] src, input logic [31:0] imm,
                       input logic [24:0] base, input logic ordy);
    in_valid  = v;
    in_immsrc = src;
    in_imm    = imm;
    in_base   = base;
    out_ready = ordy;
  endtask

  initial begin
    logic [24:0] oi;
    int          r;
    reset = 1'b1;
    drive(1'b0, 2'd0, 32'd0, 25'd0, 1'b0);
    @(posedge clk);
    #1;
    cycle();
    reset = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);

    drive(1'b1, 2'd0, 32'hFFFFFFFF, 25'd0, 1'b1);
    cycle();
    check("i_neg1_instr", {7'd0, out_instr}, 32'h1FFE000);
    check("i_neg1_err", {31'd0, out_err}, 32'd0);

    drive(1'b1, 2'd0, 32'h00000800, 25'd0, 1'b1);
    cycle();
    oi = out_instr;
    check("i_800_err", {31'd0, out_err}, 32'd1);
    check("i_800_field", {20'd0, oi[24:13]}, 32'h800);
    check("i_800_errcnt", {24'd0, err_count}, 32'd1);

    drive(1'b1, 2'd2, 32'h00000FFE, 25'd0, 1'b1);
    cycle();
    oi = out_instr;
    check("b_ffe_fields", {19'd0, oi[24], oi[23:18], oi[4:1], oi[0]}, {19'd0, 1'b0, 6'h3F, 4'hF, 1'b1});
    check("b_ffe_err", {31'd0, out_err}, 32'd0);

    drive(1'b1, 2'd2, 32'h00000003, 25'd0, 1'b1);
    cycle();
    check("b_3_err", {31'd0, out_err}, 32'd1);

    drive(1'b1, 2'd3, 32'hFFF00000, 25'd0, 1'b1);
    cycle();
    check("j_instr", {7'd0, out_instr}, 32'h1000000);
    check("j_err", {31'd0, out_err}, 32'd0);

    drive(1'b0, 2'd0, 32'd0, 25'd0, 1'b1);
    cycle();
    // Three back-to-back pushes with the consumer stalled: third must be refused.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'd1, 32'(i * 17 - 20), 25'h0ABCDE + 25'(i), 1'b0);
      cycle();
    end
    check("full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 2'd0, 32'd0, 25'd0, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: r = int'($urandom);
        1: r = int'($urandom_range(0, 8191)) - 4096;
        2: r = int'($urandom_range(0, 4194303)) - 2097152;
        default: r = (int'($urandom_range(0, 4095)) - 2048) * 2;
      endcase
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 32'(r),
            25'($urandom), $urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd0, 32'h80000000, 25'($urandom), 1'b1);
      cycle();
    end
    check("sat_errcnt", {24'd0, err_count}, 32'd255);
    drive(1'b1, 2'd3, 32'h00000010, 25'd5, 1'b0);
    cycle();
    cycle();
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 2'd0, 32'h00000001, 25'd1, 1'b1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 25'd0, 1'b0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_errcnt", {24'd0, err_count}, 32'd0);
    check("mid_rst_instr", {7'd0, out_instr}, 32'd0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
